// File: rtl/multiword_sub_if.sv
// multiword_sub_if
//   Bundles the two valid/ready streams of multiword_sub.
//   Input side:  in_valid/in_ready with in_first, in_last, x, y and bin.
//   Output side: out_valid/out_ready with diff, out_last, bout, ovf and zero.
//   modport master : the side that drives operands and consumes results (testbench or upstream logic)
//   modport slave  : the subtractor itself
interface multiword_sub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic             in_last;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             out_last;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, in_first, in_last, x, y, bin, out_ready,
        input  in_ready, out_valid, diff, out_last, bout, ovf, zero
    );

    modport slave (
        input  in_valid, in_first, in_last, x, y, bin, out_ready,
        output in_ready, out_valid, diff, out_last, bout, ovf, zero
    );
endinterface

// File: rtl/multiword_sub.sv
// multiword_sub
//   Registered multi-precision subtractor.
//   Each accepted beat computes one WIDTH-bit word of x - y - borrow.
//   Words arrive least-significant first, and the borrow is carried from beat to beat within a packet.
//   On the last beat of a packet the block also reports:
//     - signed overflow of the whole operand, and
//     - whether every result word of the packet was zero.
// Ports
//   clk    : clock; all state updates on the rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : multiword_sub_if.slave
//            input stream  (in_valid/in_ready, in_first, in_last, x, y, bin)
//            output stream (out_valid/out_ready, diff, out_last, bout, ovf, zero)
module multiword_sub #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    multiword_sub_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        CHAIN = 1'b1
    } state_t;

    // Signed overflow of x - y.
    // It can only occur when the operand signs differ.
    // It is flagged when the result sign also differs from the minuend's sign.
    function automatic logic sub_ovf(input logic x_msb, input logic y_msb, input logic d_msb);
        return (x_msb ^ y_msb) & (d_msb ^ x_msb);
    endfunction

    state_t           state_q;
    logic             borrow_q;
    logic             zacc_q;

    logic             vld_p1;
    logic [WIDTH-1:0] diff_p1;
    logic             bout_p1;
    logic             last_p1;
    logic             ovf_p1;
    logic             zero_p1;

    logic             accept_p0;
    logic             consume_p0;
    logic             first_p0;
    logic             b_p0;
    logic [WIDTH:0]   sub_p0;
    logic             zacc_p0;

    // ---- stage p0: handshake and combinational word subtraction ----
    assign bus.in_ready = ~vld_p1 | bus.out_ready;
    assign accept_p0    = bus.in_valid & bus.in_ready;
    assign consume_p0   = vld_p1 & bus.out_ready;

    // Outside a chain every beat starts a packet.
    // Inside a chain, in_first restarts the chain.
    assign first_p0 = (state_q == IDLE) | bus.in_first;
    assign b_p0     = first_p0 ? bus.bin : borrow_q;

    // The extra top bit of the widened difference is the borrow-out.
    assign sub_p0  = {1'b0, bus.x} - {1'b0, bus.y} - {{WIDTH{1'b0}}, b_p0};
    assign zacc_p0 = (first_p0 | zacc_q) & (sub_p0[WIDTH-1:0] == '0);

    // ---- stage p1: result register and chain state ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            borrow_q <= 1'b0;
            zacc_q   <= 1'b1;
            vld_p1   <= 1'b0;
            diff_p1  <= '0;
            bout_p1  <= 1'b0;
            last_p1  <= 1'b0;
            ovf_p1   <= 1'b0;
            zero_p1  <= 1'b0;
        end else if (accept_p0) begin
            state_q  <= bus.in_last ? IDLE : CHAIN;
            borrow_q <= sub_p0[WIDTH];
            zacc_q   <= zacc_p0;
            vld_p1   <= 1'b1;
            diff_p1  <= sub_p0[WIDTH-1:0];
            bout_p1  <= sub_p0[WIDTH];
            last_p1  <= bus.in_last;
            ovf_p1   <= bus.in_last & sub_ovf(bus.x[WIDTH-1], bus.y[WIDTH-1], sub_p0[WIDTH-1]);
            zero_p1  <= bus.in_last & zacc_p0;
        end else if (consume_p0) begin
            vld_p1   <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.diff      = diff_p1;
    assign bus.bout      = bout_p1;
    assign bus.out_last  = last_p1;
    assign bus.ovf       = ovf_p1;
    assign bus.zero      = zero_p1;

endmodule
